// File: rtl/sec_daec_encoder_pipe_if.sv
// Stream bundle for the SEC-DAEC encoder: message/mask in, codeword out, valid/ready on each side.
// The encoder takes the slave view; the traffic source/sink takes the master view.
interface sec_daec_encoder_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_msg;
    logic [71:0] inj_mask;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_cw;

    modport master (
        output in_valid, in_msg, inj_mask, out_ready,
        input  in_ready, out_valid, out_cw
    );

    modport slave (
        input  in_valid, in_msg, inj_mask, out_ready,
        output in_ready, out_valid, out_cw
    );
endinterface

// File: rtl/sec_daec_encoder_pipe.sv
// (72,64) SEC-DAEC encoder with fault injection into a 2-entry skid buffer; one cycle latency.
// Backpressure: in_ready (registered) drops once both entries hold words; source must hold its word.
module sec_daec_encoder_pipe #(
    parameter int CNT_W  = 32,
    parameter bit INJ_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sec_daec_encoder_pipe_if.slave    bus,
    output logic [CNT_W-1:0]          enc_count
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [63:0] M7 = 64'h95D6_5242_C4C8_D0E0;
    localparam logic [63:0] M6 = 64'hB982_A485_8991_A1C1;
    localparam logic [63:0] M5 = 64'h6ABA_C90B_1323_4383;
    localparam logic [63:0] M4 = 64'hF659_9296_2646_8607;
    localparam logic [63:0] M3 = 64'h963D_A52C_4C8C_0D0E;
    localparam logic [63:0] M2 = 64'hECFD_CA58_9819_1A1C;
    localparam logic [63:0] M1 = 64'h6B6F_14B0_3132_3438;
    localparam logic [63:0] M0 = 64'h5EE7_2961_6264_6870;

    function automatic logic [7:0] calc_chk(input logic [63:0] m);
        logic [7:0] c;
        c[7] = ^(m & M7);
        c[6] = ^(m & M6);
        c[5] = ^(m & M5);
        c[4] = ^(m & M4);
        c[3] = ^(m & M3);
        c[2] = ^(m & M2);
        c[1] = ^(m & M1);
        c[0] = ^(m & M0);
        return c;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [71:0]      head_q, head_d;
    logic [71:0]      tail_q, tail_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [71:0]      mask_eff;
    logic [71:0]      enc_word;
    logic             push, pop;

    assign mask_eff = INJ_EN ? bus.inj_mask : 72'h0;
    assign enc_word = {bus.in_msg, calc_chk(bus.in_msg)} ^ mask_eff;

    assign push = bus.in_valid & in_ready_q;
    assign pop  = (state_q != EMPTY) & bus.out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = enc_word;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d = FULL;
                    tail_d  = enc_word;
                end else if (pop && !push) begin
                    state_d = EMPTY;
                end else if (push && pop) begin
                    head_d  = enc_word;
                end
            end
            FULL: begin
                // in_ready is low here, so a pop can only promote the second entry
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d = (state_d != FULL);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pop && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_q     <= 72'h0;
            tail_q     <= 72'h0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_cw    = head_q;
    assign enc_count     = cnt_q;

endmodule

// File: tb/tb_sec_daec_encoder_pipe.sv
// Bench for sec_daec_encoder_pipe: three lockstep instances (injecting, non-injecting, 4-bit counter)
// checked against an H-matrix column model, a reference SEC-DAEC decoder and a FIFO scoreboard.
module tb_sec_daec_encoder_pipe;

    logic clk;
    logic rst_n;
    logic [31:0] cnt0;
    logic [31:0] cnt1;
    logic [3:0]  cnt2;

    sec_daec_encoder_pipe_if if0();
    sec_daec_encoder_pipe_if if1();
    sec_daec_encoder_pipe_if if2();

    assign if1.in_valid  = if0.in_valid;
    assign if1.in_msg    = if0.in_msg;
    assign if1.inj_mask  = if0.inj_mask;
    assign if1.out_ready = if0.out_ready;
    assign if2.in_valid  = if0.in_valid;
    assign if2.in_msg    = if0.in_msg;
    assign if2.inj_mask  = if0.inj_mask;
    assign if2.out_ready = if0.out_ready;

    sec_daec_encoder_pipe #(.CNT_W(32), .INJ_EN(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0), .enc_count(cnt0));
    sec_daec_encoder_pipe #(.CNT_W(32), .INJ_EN(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1), .enc_count(cnt1));
    sec_daec_encoder_pipe #(.CNT_W(4),  .INJ_EN(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2), .enc_count(cnt2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [63:0] MK [0:7] = '{
        64'h5EE7_2961_6264_6870, 64'h6B6F_14B0_3132_3438,
        64'hECFD_CA58_9819_1A1C, 64'h963D_A52C_4C8C_0D0E,
        64'hF659_9296_2646_8607, 64'h6ABA_C90B_1323_4383,
        64'hB982_A485_8991_A1C1, 64'h95D6_5242_C4C8_D0E0
    };

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Parity-check column for codeword bit p
    function automatic logic [7:0] col(input int p);
        logic [7:0] c;
        if (p < 8) begin
            c = 8'h01 << p;
        end else begin
            for (int k = 0; k < 8; k++) c[k] = MK[k][p-8];
        end
        return c;
    endfunction

    function automatic logic [7:0] chk_of(input logic [63:0] m);
        logic [7:0] s = 8'h0;
        for (int i = 0; i < 64; i++) if (m[i]) s ^= col(i + 8);
        return s;
    endfunction

    function automatic void decode(input logic [71:0] cw, output logic [1:0] typ,
                                   output logic [6:0] addr, output logic [71:0] fixed);
        logic [7:0] syn;
        logic       found;
        syn   = chk_of(cw[71:8]) ^ cw[7:0];
        typ   = 2'b00;
        addr  = 7'd0;
        fixed = cw;
        found = (syn == 8'h0);
        for (int p = 0; p < 72; p++) begin
            if (!found && col(p) == syn) begin
                found = 1'b1; typ = 2'b01; addr = 7'(p); fixed[p] = ~fixed[p];
            end
        end
        for (int p = 0; p < 71; p++) begin
            if (!found && (col(p) ^ col(p + 1)) == syn) begin
                found = 1'b1; typ = 2'b10; addr = 7'(p);
                fixed[p] = ~fixed[p]; fixed[p+1] = ~fixed[p+1];
            end
        end
        if (!found) typ = 2'b11;
    endfunction

    typedef struct {
        logic [71:0] cw;
        logic [71:0] plain;
        logic [71:0] mask;
    } exp_t;

    exp_t        q[$];
    int          pops;
    exp_t        e;
    logic [1:0]  typ, etyp;
    logic [6:0]  addr, eaddr;
    logic [71:0] fixed;

    // Scoreboard: push on input handshake, pop and compare on output handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            pops = 0;
        end else begin
            if (if0.out_valid && if0.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out got=%h exp=none at %0t", if0.out_cw, $time);
                end else begin
                    e = q.pop_front();
                    pops++;
                    check("cw", if0.out_cw, e.cw);
                    check("noinj_vld", if1.out_valid, 1'b1);
                    check("noinj_cw", if1.out_cw, e.plain);
                    etyp  = 2'b00;
                    eaddr = 7'd0;
                    if ($countones(e.mask) != 0) begin
                        etyp = ($countones(e.mask) == 1) ? 2'b01 : 2'b10;
                        for (int p = 71; p >= 0; p--) if (e.mask[p]) eaddr = 7'(p);
                    end
                    decode(if0.out_cw, typ, addr, fixed);
                    check("dec_type", typ, etyp);
                    if (etyp != 2'b00) check("dec_addr", addr, eaddr);
                    check("dec_msg", fixed[71:8], e.plain[71:8]);
                    decode(if1.out_cw, typ, addr, fixed);
                    check("noinj_type", typ, 2'b00);
                end
            end
            if (if0.in_valid && if0.in_ready) begin
                e.plain = {if0.in_msg, chk_of(if0.in_msg)};
                e.mask  = if0.inj_mask;
                e.cw    = e.plain ^ if0.inj_mask;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [63:0] m, input logic [71:0] k);
        logic acc;
        int   budget;
        if0.in_valid = 1'b1;
        if0.in_msg   = m;
        if0.inj_mask = k;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 300) begin
            @(negedge clk);
            acc = if0.in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=no_accept exp=accept msg=%h", m);
        end
        if0.in_valid = 1'b0;
        if0.in_msg   = {$urandom, $urandom};
        if0.inj_mask = {8'($urandom), $urandom, $urandom};
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d exp=0 words left", q.size());
        end
    endtask

    typedef struct {
        logic [63:0] msg;
        logic [71:0] mask;
        logic [71:0] exp;
    } vec_t;

    vec_t tbl[4];
    bit   done;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{64'h0,                   72'h0,   72'h0};
        tbl[1] = '{64'h1,                   72'h0,   72'h00_0000_0000_0000_0170};
        tbl[2] = '{64'h8000_0000_0000_0000, 72'h0,   72'h80_0000_0000_0000_00DC};
        tbl[3] = '{64'h1,                   72'h100, 72'h00_0000_0000_0000_0070};

        rst_n         = 1'b0;
        if0.in_valid  = 1'b0;
        if0.in_msg    = 64'h0;
        if0.inj_mask  = 72'h0;
        if0.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", if0.in_ready, 1'b0);
        check("rst_out_valid", if0.out_valid, 1'b0);
        check("rst_count", cnt0, 0);
        check("rst_out_cw", if0.out_cw, 72'h0);
        check("rst_count4", cnt2, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_rst", if0.in_ready, 1'b1);

        // Directed vectors: one word at a time, codeword must be visible right after accept
        if0.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(tbl[i].msg, tbl[i].mask);
            check("tbl_vld", if0.out_valid, 1'b1);
            check("tbl_cw", if0.out_cw, tbl[i].exp);
            @(posedge clk);
            #1;
            check("tbl_count", cnt0, 72'(i + 1));
        end

        // Random stream with random downstream stalls
        do_reset();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) send({$urandom, $urandom}, 72'h0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    if (!done) if0.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        if0.out_ready = 1'b1;
        drain();
        check("count_1000", cnt0, 1000);
        check("count4_sat", cnt2, 4'hF);

        // Single and adjacent-double injections across every position
        do_reset();
        if0.out_ready = 1'b1;
        for (int j = 0; j < 72; j++) send({$urandom, $urandom}, 72'h1 << j);
        for (int j = 0; j < 71; j++) send({$urandom, $urandom}, 72'h3 << j);
        drain();
        check("count_inj", cnt0, 143);
        check("count4_hold", cnt2, 4'hF);

        // Stall: downstream blocked with a continuous input stream
        do_reset();
        begin
            logic [63:0] sm [0:2];
            logic        ir;
            int          k;
            sm[0] = 64'hA5A5_0000_1111_2222;
            sm[1] = 64'h5A5A_3333_4444_5555;
            sm[2] = 64'h0F0F_6666_7777_8888;
            k = 0;
            for (int c = 0; c < 5; c++) begin
                if0.in_valid = 1'b1;
                if0.in_msg   = sm[k];
                if0.inj_mask = 72'h0;
                @(negedge clk);
                ir = if0.in_ready;
                check("stall_rdy", ir, (c < 2));
                if (ir) k++;
                @(posedge clk);
                #1;
            end
            check("stall_accepted", k, 2);
            if0.out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("rdy_after_pop", if0.in_ready, 1'b1);
            if0.in_valid = 1'b0;
            drain();
            check("stall_count", cnt0, 2);
        end

        // Reset while FULL discards both buffered words
        if0.out_ready = 1'b0;
        send(64'hDEAD_BEEF_0000_0001, 72'h0);
        send(64'hDEAD_BEEF_0000_0002, 72'h0);
        check("full_rdy", if0.in_ready, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstfull_vld", if0.out_valid, 1'b0);
        check("rstfull_count", cnt0, 0);
        check("rstfull_cw", if0.out_cw, 72'h0);
        check("rstfull_count4", cnt2, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if0.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rstfull_no_emit", if0.out_valid, 1'b0);
        check("rstfull_count_after", cnt0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sec_daec_encoder_pipe.md
Name: sec_daec_encoder_pipe

Overview:
- Streaming (72,64) SEC-DAEC encoder: accepts 64-bit messages over valid/ready and emits systematic 72-bit codewords.
- Codeword layout: codeword[71:8] = message[63:0]; codeword[7:0] = check bits.
- Produces exactly the code our SEC-DAEC decoder corrects: syndrome of any emitted, uninjected codeword = 8'h00.
- Sits on the write path to protected memory. Provides per-word fault injection for decoder verification and an encoded-word counter.

Parameters:
- CNT_W, 32, width of the encoded-word counter (saturating).
- INJ_EN, 1, 1 = honour inj_mask; 0 = inj_mask ignored and treated as all zeros.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset: one clock, synchronous, active-low.
- in_valid  input  1  message presented.
- in_ready  output  1  encoder can accept; registered.
- in_msg  input  64  message word.
- inj_mask  input  72  XOR fault mask; sampled together with in_msg.
- out_valid  output  1  codeword available.
- out_ready  input  1  downstream accepts.
- out_cw  output  72  encoded (and optionally injected) codeword.
- enc_count  output  CNT_W  number of completed output handshakes.

Behaviour:
- Check bit k = XOR of (in_msg & Mk), with:
  - M7 = 64'h95D6_5242_C4C8_D0E0
  - M6 = 64'hB982_A485_8991_A1C1
  - M5 = 64'h6ABA_C90B_1323_4383
  - M4 = 64'hF659_9296_2646_8607
  - M3 = 64'h963D_A52C_4C8C_0D0E
  - M2 = 64'hECFD_CA58_9819_1A1C
  - M1 = 64'h6B6F_14B0_3132_3438
  - M0 = 64'h5EE7_2961_6264_6870
- Stored word = {in_msg, chk} ^ (INJ_EN ? inj_mask : 0). Encoding is computed at the input and stored in the buffer; there is no output-side logic.
- Buffer: 2-entry elastic buffer (skid).
  - States: EMPTY, ONE, FULL.
  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
- State transitions:
  - EMPTY: push -> ONE.
  - ONE: push & !pop -> FULL; pop & !push -> EMPTY; push & pop -> ONE (new word becomes head next cycle).
  - FULL: pop -> ONE (second entry becomes head); no push possible.
- Outputs from state:
  - out_valid = (state != EMPTY).
  - out_cw = head entry, held stable while out_valid & !out_ready.
  - in_ready = registered (next_state != FULL).
- Latency: word pushed at edge N appears on out_cw after edge N (out_valid high in cycle N+1) when the buffer was empty.
- Throughput: 1 word/cycle sustained with out_ready held high. Order strictly FIFO; no drop, no duplication.
- Backpressure: out_ready low for 2+ cycles with a continuous input stream -> FULL, in_ready deasserts the following cycle. The input word present on that cycle is not consumed and must be held by the source.
- Counter: enc_count increments by 1 per pop; saturates at all-ones (no wrap).
- Reset (rst_n low at an edge):
  - state = EMPTY, out_valid = 0, in_ready = 0, enc_count = 0, out_cw = 72'h0.
  - in_ready rises on the first edge with rst_n high.
  - Reset mid-stream discards buffered words without emitting them.
- Inputs while in_ready = 0, or while in_valid = 0, are ignored. X on in_msg while in_valid = 0 must not propagate to out_cw.

Test Plan:
- Reset then push in_msg = 64'h0, inj_mask = 0 -> out_cw = 72'h0 one cycle after accept; enc_count = 1 after pop.
- Push in_msg = 64'h1 -> out_cw = 72'h00_0000_0000_0000_0170; push in_msg = 64'h8000_0000_0000_0000 -> out_cw = 72'h80_0000_0000_0000_00DC.
- Push 1000 random messages with out_ready random (50%) -> outputs in order, each matching the golden model, and every uninjected codeword decodes with error_type 2'b00. enc_count = 1000.
- Injection: inj_mask = 1 << j for all j in 0..71, then 3 << j for j in 0..70 -> decoder reports error_type 01/10 with the matching address and recovers the message. With INJ_EN = 0, same stimulus -> error_type 00.
- Stall: out_ready = 0 for 5 cycles with in_valid = 1 -> exactly 2 words accepted, in_ready = 0 from the third cycle. Release -> words drain in order and in_ready returns 1 the cycle after the first pop.
- Assert rst_n low with the buffer FULL -> out_valid = 0, enc_count = 0 after the edge. Buffered words are never emitted.
- Force enc_count near saturation (CNT_W = 4 build): 20 pops -> count holds at 4'hF.
